// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit with PC, ROM address drive and {pc, inst} prefetch queue
module ifu_prefetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   input  logic                  halt_i,
   output logic                  id_valid_o,
   input  logic                  id_ready_i,
   output logic [DATA_WIDTH-1:0] id_inst_o,
   output logic [ADDR_WIDTH-1:0] id_pc_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] mem_inst [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];

   logic push;
   logic pop;

   // Handshake and fetch qualification; redirect voids both directions in its cycle.
   always_comb begin
      id_valid_o = (count != '0) & ~redirect_i;
      pop        = id_valid_o & id_ready_i;
      push       = ~redirect_i & ~halt_i & ((count < DEPTH_C) | pop);
   end

   assign rom_addr_o = pc_q;
   assign id_inst_o  = mem_inst[rd_ptr];
   assign id_pc_o    = mem_pc[rd_ptr];

   // PC, pointers and occupancy; redirect flushes the queue and reloads the PC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC_A;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_i) begin
         pc_q   <= redirect_pc_i & ALIGN_MASK;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc_q   <= pc_q + ADDR_WIDTH'(4);
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue storage; cleared on reset so the head reads as zero until the first fetch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_inst[i] <= '0;
            mem_pc[i]   <= '0;
         end
      end else if (push) begin
         mem_inst[wr_ptr] <= rom_data_i;
         mem_pc[wr_ptr]   <= pc_q;
      end
   end

endmodule
